// File: rtl/stage_fetch_queue.sv
// stage_fetch_queue: instruction-fetch stage. It keeps a DEPTH-entry prefetch
// queue of {instruction, pc, next_pc} records between the instruction ROM and
// decode. It supports a combinational or a registered ROM, a branch redirect
// that flushes the queue and kills any in-flight fetch, and a sticky EBREAK stop.
module stage_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DEPTH       = 4,
  parameter int                    ROM_LATENCY = 0,
  parameter int                    PC_STEP     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_target,
  input  logic                          ebreak_in,
  output logic [ADDR_WIDTH-1:0]         rom_address,
  output logic                          rom_enable,
  input  logic [WORD_WIDTH-1:0]         rom_data,
  output logic                          out_valid,
  output logic [WORD_WIDTH-1:0]         out_instr,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [ADDR_WIDTH-1:0]         out_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          cpu_stop
);

  localparam int                    PTR_W = $clog2(DEPTH);
  localparam int                    OCC_W = $clog2(DEPTH + 1);
  localparam int                    LVL_W = OCC_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
  localparam bit                    LAT1  = (ROM_LATENCY == 1);

  // PC increment, wrapping modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + STEP;
  endfunction

  // Control state.
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [OCC_W-1:0]      occ;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  stop_q;
  logic                  vld_p1;

  // Datapath state: queue storage and the pc of an outstanding registered fetch.
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic [WORD_WIDTH-1:0] q_instr   [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc      [DEPTH];
  logic [ADDR_WIDTH-1:0] q_next_pc [DEPTH];

  logic                  pop;
  logic                  issue;
  logic                  push;
  logic [LVL_W-1:0]      level;
  logic [ADDR_WIDTH-1:0] push_pc;

  // Pop/issue/push decisions. The issue rule counts the outstanding fetch as
  // an occupied slot, so a push can never land in a full queue.
  always_comb begin
    pop     = (occ != '0) & ~stall & ~redirect;
    level   = {1'b0, occ} + LVL_W'(vld_p1) - LVL_W'(pop);
    issue   = reset & ~stop_q & ~redirect & (level < LVL_W'(DEPTH));
    push    = LAT1 ? (vld_p1 & ~redirect) : issue;
    push_pc = LAT1 ? pc_p1 : fetch_pc;
  end

  // Fetch PC, queue pointers, occupancy, in-flight flag and the sticky stop.
  // Redirect wins over everything and empties the queue and the fetch pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      vld_p1   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      stop_q <= stop_q | ebreak_in;
      if (redirect) begin
        fetch_pc <= redirect_target;
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        vld_p1   <= 1'b0;
      end else begin
        if (issue) begin
          fetch_pc <= pc_inc(fetch_pc);
        end
        vld_p1 <= LAT1 & issue;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
    end
  end

  // Fetch pipe p0 -> p1 and queue writes; data needs no reset because every
  // read is qualified by the control state above.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_p1 <= fetch_pc;
    end
    if (push) begin
      q_instr[wr_ptr]   <= rom_data;
      q_pc[wr_ptr]      <= push_pc;
      q_next_pc[wr_ptr] <= pc_inc(push_pc);
    end
  end

  assign rom_address = fetch_pc;
  assign rom_enable  = issue;
  assign out_valid   = (occ != '0);
  assign out_instr   = q_instr[rd_ptr];
  assign out_pc      = q_pc[rd_ptr];
  assign out_next_pc = q_next_pc[rd_ptr];
  assign occupancy   = occ;
  assign cpu_stop    = stop_q;

endmodule

// File: tb/tb_stage_fetch_queue.sv
// Bench for stage_fetch_queue: one instance with a combinational ROM and one
// with a registered ROM, driven by the same directed stimulus and checked
// against a queue-level reference model plus hand-computed expectations.
module tb_stage_fetch_queue;

  localparam int AW    = 10;
  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          stall    = 1'b0;
  logic          redirect = 1'b0;
  logic          ebreak   = 1'b0;
  logic [AW-1:0] target   = '0;

  logic [AW-1:0] addr0, addr1, pc0, pc1, npc0, npc1;
  logic          en0, en1, val0, val1, stop0, stop1;
  logic [WW-1:0] data0, data1, instr0, instr1;
  logic [OW-1:0] occ0, occ1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM contents: word index i holds value i.
  function automatic logic [WW-1:0] rom_word(input logic [AW-1:0] a);
    return WW'(a >> 2);
  endfunction

  assign data0 = rom_word(addr0);
  always @(posedge clk) data1 <= rom_word(addr1);

  stage_fetch_queue #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH),
                      .ROM_LATENCY(0), .PC_STEP(4), .RESET_PC('0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(target), .ebreak_in(ebreak), .rom_address(addr0),
    .rom_enable(en0), .rom_data(data0), .out_valid(val0), .out_instr(instr0),
    .out_pc(pc0), .out_next_pc(npc0), .occupancy(occ0), .cpu_stop(stop0));

  stage_fetch_queue #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH),
                      .ROM_LATENCY(1), .PC_STEP(4), .RESET_PC('0)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(target), .ebreak_in(ebreak), .rom_address(addr1),
    .rom_enable(en1), .rom_data(data1), .out_valid(val1), .out_instr(instr1),
    .out_pc(pc1), .out_next_pc(npc1), .occupancy(occ1), .cpu_stop(stop1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, a list of queued pcs (index 0 = head),
  // the fetch pc, an optional outstanding fetch (registered ROM only) and stop.
  int m_q    [2][16];
  int m_n    [2] = '{0, 0};
  int m_pc   [2] = '{0, 0};
  bit m_pend [2] = '{1'b0, 1'b0};
  int m_ppc  [2] = '{0, 0};
  bit m_stop [2] = '{1'b0, 1'b0};

  function automatic bit m_pop_f(input int k);
    return (m_n[k] > 0) && !stall && !redirect;
  endfunction

  function automatic bit m_iss_f(input int k);
    return !m_stop[k] && !redirect &&
           (m_n[k] + int'(m_pend[k]) - int'(m_pop_f(k)) < DEPTH);
  endfunction

  // Model state update at every clock edge; reset clears it immediately.
  always @(posedge clk or negedge reset) begin : model
    bit p, iss;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_pc[k] = 0; m_pend[k] = 1'b0; m_stop[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        p   = m_pop_f(k);
        iss = m_iss_f(k);
        if (redirect) begin
          m_n[k] = 0; m_pend[k] = 1'b0; m_pc[k] = int'(target);
        end else begin
          if (p) begin
            for (int j = 0; j < 15; j++) m_q[k][j] = m_q[k][j+1];
            m_n[k]--;
          end
          if (k == 0 && iss && m_n[k] < 16) begin
            m_q[k][m_n[k]] = m_pc[k]; m_n[k]++;
          end
          if (k == 1) begin
            if (m_pend[k] && m_n[k] < 16) begin
              m_q[k][m_n[k]] = m_ppc[k]; m_n[k]++;
            end
            m_pend[k] = iss;
            m_ppc[k]  = m_pc[k];
          end
          if (iss) m_pc[k] = (m_pc[k] + 4) % 1024;
        end
        if (ebreak) m_stop[k] = 1'b1;
      end
    end
  end

  task automatic cmp(input int k, input logic [AW-1:0] addr, input logic en,
                     input logic val, input logic [WW-1:0] instr,
                     input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                     input logic [OW-1:0] occ, input logic stop);
    chk($sformatf("d%0d_occupancy", k), 32'(occ), 32'(m_n[k]));
    chk($sformatf("d%0d_occ_bound", k), 32'(occ <= DEPTH), 32'd1);
    chk($sformatf("d%0d_out_valid", k), 32'(val), 32'(m_n[k] > 0));
    chk($sformatf("d%0d_rom_address", k), 32'(addr), 32'(m_pc[k]));
    chk($sformatf("d%0d_rom_enable", k), 32'(en), 32'(reset && m_iss_f(k)));
    chk($sformatf("d%0d_cpu_stop", k), 32'(stop), 32'(m_stop[k]));
    if (m_n[k] > 0) begin
      chk($sformatf("d%0d_out_pc", k), 32'(pc), 32'(m_q[k][0]));
      chk($sformatf("d%0d_out_next_pc", k), 32'(npc), 32'((m_q[k][0] + 4) % 1024));
      chk($sformatf("d%0d_out_instr", k), instr, rom_word(AW'(m_q[k][0])));
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp(0, addr0, en0, val0, instr0, pc0, npc0, occ0, stop0);
    cmp(1, addr1, en1, val1, instr1, pc1, npc1, occ1, stop1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; ebreak = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_occ0", 32'(occ0), 0);
    chk("rst_val0", 32'(val0), 0);
    chk("rst_en0", 32'(en0), 0);
    chk("rst_stop0", 32'(stop0), 0);
    chk("rst_addr0", 32'(addr0), 0);
    chk("rst_en1", 32'(en1), 0);

    // Streaming, no stall.
    do_reset();
    tick();
    chk("t1_val0", 32'(val0), 1);
    chk("t1_pc0", 32'(pc0), 0);
    chk("t1_npc0", 32'(npc0), 4);
    chk("t1_instr0", instr0, 0);
    chk("t1_val1_early", 32'(val1), 0);
    tick();
    chk("t1_pc0_b", 32'(pc0), 4);
    chk("t1_instr0_b", instr0, 1);
    chk("t1_val1", 32'(val1), 1);
    chk("t1_pc1", 32'(pc1), 0);
    repeat (4) tick();
    chk("t1_pc0_c", 32'(pc0), 20);
    chk("t1_pc1_c", 32'(pc1), 16);
    chk("t1_occ0", 32'(occ0), 1);
    chk("t1_addr0", 32'(addr0), 24);

    // Stall fills the queue, then back-to-back drain.
    do_reset();
    stall = 1'b1;
    repeat (4) tick();
    chk("t2_occ0", 32'(occ0), 4);
    chk("t2_en0", 32'(en0), 0);
    chk("t2_addr0", 32'(addr0), 16);
    chk("t2_pc0", 32'(pc0), 0);
    tick();
    chk("t2_occ1", 32'(occ1), 4);
    chk("t2_en1", 32'(en1), 0);
    chk("t2_addr1", 32'(addr1), 16);
    repeat (5) tick();
    chk("t2_occ0_held", 32'(occ0), 4);
    chk("t2_addr0_held", 32'(addr0), 16);
    stall = 1'b0;
    #1;
    chk("t2_en0_release", 32'(en0), 1);
    chk("t2_drain_pc0", 32'(pc0), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_drain_val0", 32'(val0), 1);
      chk("t2_drain_pc0", 32'(pc0), 32'(4 * i));
    end

    // Redirect while full.
    do_reset();
    stall = 1'b1;
    repeat (5) tick();
    redirect = 1'b1;
    target   = 10'h100;
    #1;
    chk("t3_en0_redirect", 32'(en0), 0);
    chk("t3_en1_redirect", 32'(en1), 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_occ0", 32'(occ0), 0);
    chk("t3_val0", 32'(val0), 0);
    chk("t3_occ1", 32'(occ1), 0);
    chk("t3_val1", 32'(val1), 0);
    chk("t3_addr0", 32'(addr0), 32'h100);
    chk("t3_addr1", 32'(addr1), 32'h100);
    stall = 1'b0;
    tick();
    chk("t3_val0_b", 32'(val0), 1);
    chk("t3_pc0", 32'(pc0), 32'h100);
    chk("t3_val1_b", 32'(val1), 0);
    tick();
    chk("t3_val1_c", 32'(val1), 1);
    chk("t3_pc1", 32'(pc1), 32'h100);

    // Redirect kills the in-flight registered fetch.
    do_reset();
    repeat (4) tick();
    chk("t4_pc1_before", 32'(pc1), 8);
    redirect = 1'b1;
    target   = 10'h40;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_val0", 32'(val0), 0);
    chk("t4_val1", 32'(val1), 0);
    chk("t4_addr1", 32'(addr1), 32'h40);
    tick();
    chk("t4_val0_b", 32'(val0), 1);
    chk("t4_pc0", 32'(pc0), 32'h40);
    chk("t4_val1_b", 32'(val1), 0);
    tick();
    chk("t4_val1_c", 32'(val1), 1);
    chk("t4_pc1", 32'(pc1), 32'h40);
    chk("t4_instr1", instr1, 32'h10);

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    target   = 10'h3FC;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_addr0", 32'(addr0), 32'h3FC);
    chk("t5_en0", 32'(en0), 1);
    tick();
    chk("t5_pc0", 32'(pc0), 32'h3FC);
    chk("t5_npc0", 32'(npc0), 0);
    chk("t5_instr0", instr0, 255);
    chk("t5_addr0_wrap", 32'(addr0), 0);
    tick();
    chk("t5_pc1", 32'(pc1), 32'h3FC);
    chk("t5_npc1", 32'(npc1), 0);
    chk("t5_pc0_wrap", 32'(pc0), 0);

    // EBREAK stop, drain, then reset mid-drain.
    do_reset();
    repeat (9) tick();
    chk("t6_pc0_at", 32'(pc0), 32'h20);
    chk("t6_pc1_at", 32'(pc1), 32'h1C);
    ebreak = 1'b1;
    stall  = 1'b1;
    tick();
    ebreak = 1'b0;
    stall  = 1'b0;
    #1;
    chk("t6_stop0", 32'(stop0), 1);
    chk("t6_stop1", 32'(stop1), 1);
    chk("t6_en0", 32'(en0), 0);
    chk("t6_en1", 32'(en1), 0);
    chk("t6_occ0", 32'(occ0), 2);
    chk("t6_pc0", 32'(pc0), 32'h20);
    chk("t6_occ1", 32'(occ1), 2);
    chk("t6_pc1", 32'(pc1), 32'h1C);
    tick();
    chk("t6_stop0_b", 32'(stop0), 1);
    chk("t6_en0_b", 32'(en0), 0);
    chk("t6_pc0_b", 32'(pc0), 32'h24);
    chk("t6_occ0_b", 32'(occ0), 1);
    chk("t6_occ1_b", 32'(occ1), 2);
    chk("t6_pc1_b", 32'(pc1), 32'h20);
    reset = 1'b0;
    #1;
    chk("t6_rst_occ0", 32'(occ0), 0);
    chk("t6_rst_val0", 32'(val0), 0);
    chk("t6_rst_stop0", 32'(stop0), 0);
    chk("t6_rst_en0", 32'(en0), 0);
    chk("t6_rst_addr0", 32'(addr0), 0);
    chk("t6_rst_occ1", 32'(occ1), 0);
    chk("t6_rst_val1", 32'(val1), 0);
    chk("t6_rst_stop1", 32'(stop1), 0);
    chk("t6_rst_en1", 32'(en1), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_fetch_queue.md
Name: stage_fetch_queue

Overview:
Parametrised instruction-fetch stage that decouples the program counter from decode with a DEPTH-entry prefetch queue of {instruction, pc, next_pc} records. It supports combinational or registered instruction ROM (ROM_LATENCY 0/1), branch redirect with queue flush and in-flight kill, and a sticky EBREAK stop. It sits between the instruction ROM and the decode stage, and takes redirect/ebreak from the memory stage.

Parameters:
ADDR_WIDTH, 10, ROM address / PC width in bits
WORD_WIDTH, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
ROM_LATENCY, 0, 0 = rom_data valid same cycle as rom_address; 1 = valid next cycle
PC_STEP, 4, increment added to PC per fetch
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  decode not accepting; head entry held
redirect  in  1  take branch this cycle
redirect_target  in  ADDR_WIDTH  new fetch PC
ebreak_in  in  1  EBREAK reached memory stage
rom_address  out  ADDR_WIDTH  fetch address
rom_enable  out  1  a fetch is issued this cycle
rom_data  in  WORD_WIDTH  instruction word
out_valid  out  1  head entry valid
out_instr  out  WORD_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  head pc
out_next_pc  out  ADDR_WIDTH  head pc + PC_STEP (mod 2^ADDR_WIDTH)
occupancy  out  clog2(DEPTH+1)  entries in queue
cpu_stop  out  1  sticky stop flag

Behaviour:
- Reset (asynchronous, while reset=0): fetch_pc=RESET_PC, queue empty, occupancy=0, out_valid=0, in-flight cleared, cpu_stop=0, rom_enable=0. The out_instr/out_pc/out_next_pc values are don't-care while out_valid=0.
- pop = out_valid & !stall & !redirect. Pop on an empty queue is a no-op.
- Issue condition: rom_enable = !cpu_stop & !redirect & (occupancy + inflight - pop < DEPTH).
  - inflight = 1 if a ROM_LATENCY=1 fetch is outstanding; otherwise 0.
  - rom_address = fetch_pc, driven combinationally every cycle.
  - On issue, fetch_pc <= fetch_pc + PC_STEP, wrapping modulo 2^ADDR_WIDTH.
- Push timing:
  - ROM_LATENCY=0: on issue, the entry {rom_data, fetch_pc, fetch_pc+PC_STEP} is pushed at the same clock edge.
  - ROM_LATENCY=1: the issued pc is registered, and the entry is pushed one edge later with that cycle's rom_data.
- Simultaneous push and pop: occupancy unchanged. Push into a full queue must never occur; the issue rule guarantees this, and the bench asserts it.
- Queue is FIFO. Read/write pointers are log2(DEPTH) bits and wrap naturally. The head appears on out_* combinationally from storage, so there is 0 extra latency once an entry is written.
- Latency:
  - ROM_LATENCY=0: first out_valid the cycle after reset deasserts.
  - ROM_LATENCY=1: first out_valid one cycle after that.
- Redirect (highest priority): at the edge, queue flushed (occupancy=0), any in-flight response discarded, fetch_pc <= redirect_target. No push or pop that cycle. Fetch resumes the next cycle, and out_valid is 0 for at least that cycle.
- ebreak_in: cpu_stop <= 1 at the next edge and stays set until reset. While cpu_stop=1:
  - no new issues;
  - an in-flight response is still pushed;
  - the queue still drains via pop.
  - A redirect in the same cycle as ebreak_in still flushes, and cpu_stop still sets.
- stall never blocks issue while space remains; the queue fills to DEPTH, then rom_enable=0.
- All state is on the rising clk edge except the asynchronous reset. Reset mid-operation discards all entries immediately.

Test Plan:
1. Reset release, ROM_LATENCY=0, DEPTH=4, ROM[i]=i, stall=0 -> out_pc sequence 0,4,8,... one per cycle; out_next_pc=out_pc+4; occupancy stays <=1.
2. stall held high 10 cycles -> occupancy rises to 4, then rom_enable=0 and fetch_pc frozen at 16. Release stall -> pcs 0,4,8,12,16 delivered back-to-back with no gap.
3. Queue full with stall high, then redirect with target 0x100 -> next cycle occupancy=0, out_valid=0. Following cycle rom_address=0x100; first valid out_pc=0x100.
4. ROM_LATENCY=1: redirect raised while a fetch is in flight -> the in-flight word is never presented; first out_pc after the redirect equals the target.
5. fetch_pc=2^ADDR_WIDTH-4 -> next fetch address 0; the entry's out_next_pc=0.
6. ebreak_in pulsed at pc 0x20 -> cpu_stop=1 the next cycle and stays 1; rom_enable=0 forever; remaining entries drain; assert reset low mid-drain -> all outputs at reset values immediately.
